phase_accum_mc: RTL

PHASE_ACCUM_MC -- requirements
Module: phase_accum_mc

---
 rtl/phase_accum_pkg.sv | 14 +
 rtl/phase_accum_mc_adder.sv | 14 +
 rtl/phase_accum_mc.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/phase_accum_pkg.sv
// phase_accum_mc shared types and default sizes.
// Configuration FSM states and parameter defaults.
package phase_accum_pkg;

  localparam int DEF_ACC_W  = 32;
  localparam int DEF_OUT_W  = 10;
  localparam int DEF_NUM_CH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } cfg_state_e;

endpackage

// File: rtl/phase_accum_mc_adder.sv
// adder_flex_carry: WIDTH-bit adder with carry out.
// Shared by the accumulator step and the phase offset add.
module adder_flex_carry #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/phase_accum_mc.sv
// phase_accum_mc: time-multiplexed multi-channel phase accumulator.
// One channel per enabled slot; config commits in its channel's slot.
module phase_accum_mc
  import phase_accum_pkg::*;
#(
  parameter int ACC_W  = DEF_ACC_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int NUM_CH = DEF_NUM_CH,
  localparam int CH_W  = $clog2(NUM_CH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [CH_W-1:0]  i_cfg_ch,
  input  logic [ACC_W-1:0] i_cfg_fcw,
  input  logic [ACC_W-1:0] i_cfg_poff,
  input  logic             i_cfg_sync,
  output logic             o_valid,
  output logic [CH_W-1:0]  o_ch,
  output logic [OUT_W-1:0] o_phase,
  output logic             o_wrap
);

  cfg_state_e state_q, state_d;

  logic [CH_W-1:0]  slot_q;
  logic [CH_W-1:0]  slot_nxt;
  logic [ACC_W-1:0] acc_q  [NUM_CH];
  logic [ACC_W-1:0] fcw_q  [NUM_CH];
  logic [ACC_W-1:0] poff_q [NUM_CH];

  logic [CH_W-1:0]  sh_ch_q;
  logic [ACC_W-1:0] sh_fcw_q;
  logic [ACC_W-1:0] sh_poff_q;
  logic             sh_sync_q;
  logic             sh_ok_q;

  logic             hs;
  logic             commit;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W-1:0] fcw_use;
  logic [ACC_W-1:0] poff_use;
  logic [ACC_W-1:0] sum;
  logic             carry;
  logic [ACC_W-1:0] ph_full;
  logic             off_carry;
  logic             unused_off;

  assign o_cfg_ready = (state_q == IDLE);
  assign hs = i_cfg_valid && (state_q == IDLE);
  assign commit = i_en && (state_q == PEND)
               && sh_ok_q && (sh_ch_q == slot_q);

  assign slot_nxt = (slot_q == CH_W'(NUM_CH - 1))
                  ? '0 : slot_q + 1'b1;

  assign fcw_use  = commit ? sh_fcw_q  : fcw_q[slot_q];
  assign poff_use = commit ? sh_poff_q : poff_q[slot_q];
  assign acc_base = (commit && sh_sync_q)
                  ? '0 : acc_q[slot_q];

  adder_flex_carry #(.WIDTH(ACC_W)) u_acc_add (
    .a     (acc_base),
    .b     (fcw_use),
    .sum   (sum),
    .carry (carry)
  );

  adder_flex_carry #(.WIDTH(ACC_W)) u_off_add (
    .a     (acc_base),
    .b     (poff_use),
    .sum   (ph_full),
    .carry (off_carry)
  );

  assign unused_off = ^{ph_full, off_carry};

  // Config FSM next state: a request parks in PEND until its slot.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (i_cfg_valid) state_d = PEND;
      PEND: if (!sh_ok_q || commit) state_d = IDLE;
    endcase
  end

  // Config FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Shadow registers capture an accepted request.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sh_ch_q   <= '0;
      sh_fcw_q  <= '0;
      sh_poff_q <= '0;
      sh_sync_q <= 1'b0;
      sh_ok_q   <= 1'b0;
    end else if (hs) begin
      sh_ch_q   <= i_cfg_ch;
      sh_fcw_q  <= i_cfg_fcw;
      sh_poff_q <= i_cfg_poff;
      sh_sync_q <= i_cfg_sync;
      sh_ok_q   <= 32'(i_cfg_ch) < NUM_CH;
    end
  end

  // Slot schedule, channel state update and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      slot_q  <= '0;
      o_valid <= 1'b0;
      o_ch    <= '0;
      o_phase <= '0;
      o_wrap  <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c]  <= '0;
        fcw_q[c]  <= '0;
        poff_q[c] <= '0;
      end
    end else begin
      o_valid <= i_en;
      if (i_en) begin
        acc_q[slot_q] <= sum;
        if (commit) begin
          fcw_q[slot_q]  <= sh_fcw_q;
          poff_q[slot_q] <= sh_poff_q;
        end
        o_ch    <= slot_q;
        o_phase <= ph_full[ACC_W-1 -: OUT_W];
        o_wrap  <= carry;
        slot_q  <= slot_nxt;
      end
    end
  end

endmodule
